// File: rtl/operand_a_stage.sv
// ID/EX operand-A stage: selects rs1/PC with MEM/WB forwarding, detects
// load-use hazards and registers the EX-stage operand A bundle.
module operand_a_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic        asel,
  input  logic        mem_we,
  input  logic        mem_is_load,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_asel,
  output logic [31:0] out_a,
  output logic        load_use_stall
);

  // Flow control: an instruction moves into EX on an edge with stall=0;
  // stall=1 holds the bundle, flush/hazard replace it with a bubble.
  logic [4:0]  w_rs1;
  logic [4:0]  w_out_rs1;
  logic        w_hazard;
  logic [31:0] w_next_a;
  logic [31:0] w_hold_a;

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_asel;
  logic [31:0] r_a;

  assign w_rs1     = in_inst[19:15];
  assign w_out_rs1 = r_inst[19:15];

  assign w_hazard = in_valid & ~asel & mem_we & mem_is_load &
                    (mem_rd != 5'd0) & (mem_rd == w_rs1);

  assign load_use_stall = ~rst & w_hazard & ~flush & ~stall;

  always_comb begin
    w_next_a = in_rs1_data;
    if (asel) begin
      w_next_a = in_pc;
    end else if (mem_we && !mem_is_load && mem_rd == w_rs1 && w_rs1 != 5'd0) begin
      w_next_a = mem_data;
    end else if (wb_we && wb_rd == w_rs1 && w_rs1 != 5'd0) begin
      w_next_a = wb_data;
    end
  end

  // While held, a waiting rs1 consumer keeps picking up late ALU/WB results.
  always_comb begin
    w_hold_a = r_a;
    if (r_valid && !r_asel && w_out_rs1 != 5'd0) begin
      if (mem_we && !mem_is_load && mem_rd == w_out_rs1) begin
        w_hold_a = mem_data;
      end else if (wb_we && wb_rd == w_out_rs1) begin
        w_hold_a = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= 32'd0;
      r_asel  <= 1'b0;
      r_a     <= 32'd0;
    end else if (flush || (!stall && w_hazard)) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= in_pc;
      r_asel  <= 1'b0;
      r_a     <= 32'd0;
    end else if (stall) begin
      r_a     <= w_hold_a;
    end else begin
      r_valid <= in_valid;
      r_inst  <= in_inst;
      r_pc    <= in_pc;
      r_asel  <= asel;
      r_a     <= w_next_a;
    end
  end

  assign out_valid = r_valid;
  assign out_inst  = r_inst;
  assign out_pc    = r_pc;
  assign out_asel  = r_asel;
  assign out_a     = r_a;

endmodule
